// File: rtl/stopwatch_run_ctrl.sv
// Stopwatch run/lap/reset controller: debounces the two front-panel buttons and
// sequences counter enable/clear and display lap freeze from a 4-state FSM.

module stopwatch_btn_cond #(
  parameter int DB_CYCLES = 62500,
  parameter int DB_W      = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            s1_q, s2_q;
  logic            db_q, db_d;
  logic            arm_q, arm_d;
  logic            p_q, p_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Until armed, the counter measures how long the synced level has been low; a
  // button held through reset keeps it unarmed until a stable release is seen.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    arm_d = arm_q;
    p_d   = 1'b0;
    if (!arm_q) begin
      if (!s2_q) begin
        if (cnt_q == DB_LAST) arm_d = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end
    end else if (s2_q != db_q) begin
      if (cnt_q == DB_LAST) begin
        db_d = s2_q;
        p_d  = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      arm_q <= 1'b0;
      p_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_raw;
      s2_q  <= s1_q;
      db_q  <= db_d;
      arm_q <= arm_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
    end
  end

  assign press = p_q;
endmodule

module stopwatch_run_ctrl #(
  parameter int DB_CYCLES = 62500,
  parameter int DB_W      = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       cnt_max,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_latch,
  output logic       disp_hold,
  output logic       run_led,
  output logic [1:0] state
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10,
    ST_STOP = 2'b11
  } state_t;

  logic   ss_p, lr_p;
  logic   counting, max_ev;
  state_t state_q, state_d;
  logic   cnt_clr_q, cnt_clr_d;
  logic   disp_latch_q, disp_latch_d;
  logic   disp_hold_q, disp_hold_d;

  stopwatch_btn_cond #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_ss (
    .clk(clk), .rst(rst), .btn_raw(btn_ss), .press(ss_p)
  );
  stopwatch_btn_cond #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_lr (
    .clk(clk), .rst(rst), .btn_raw(btn_lr), .press(lr_p)
  );

  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign max_ev   = counting && cnt_max && tick;

  // Priority: counter full beats both presses; start/stop beats lap/reset.
  always_comb begin
    state_d      = state_q;
    cnt_clr_d    = 1'b0;
    disp_latch_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_p)      state_d = ST_RUN;
        else if (lr_p) cnt_clr_d = 1'b1;
      end
      ST_RUN: begin
        if (max_ev || ss_p) state_d = ST_STOP;
        else if (lr_p) begin
          state_d      = ST_LAP;
          disp_latch_d = 1'b1;
        end
      end
      ST_LAP: begin
        if (max_ev || ss_p) state_d = ST_STOP;
        else if (lr_p)      state_d = ST_RUN;
      end
      ST_STOP: begin
        if (ss_p) state_d = ST_RUN;
        else if (lr_p) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    disp_hold_d = (state_d == ST_LAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_clr_q    <= 1'b0;
      disp_latch_q <= 1'b0;
      disp_hold_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_clr_q    <= cnt_clr_d;
      disp_latch_q <= disp_latch_d;
      disp_hold_q  <= disp_hold_d;
    end
  end

  // Gated by cnt_max so the counter never wraps 999.99 -> 000.00.
  assign cnt_en     = tick && counting && !cnt_max;
  assign cnt_clr    = cnt_clr_q;
  assign disp_latch = disp_latch_q;
  assign disp_hold  = disp_hold_q;
  assign run_led    = counting;
  assign state      = state_q;
endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Directed bench for stopwatch_run_ctrl with DB_CYCLES=4 (press latency 7 clks).

module tb_stopwatch_run_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       cnt_max = 1'b0;
  logic       cnt_en, cnt_clr, disp_latch, disp_hold, run_led;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  stopwatch_run_ctrl #(.DB_CYCLES(4), .DB_W(17)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .cnt_max(cnt_max), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .disp_latch(disp_latch), .disp_hold(disp_hold), .run_led(run_led),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Raw buttons go high; the FSM reacts on the 7th edge afterwards.
  task automatic press(input logic ss, input logic lr);
    btn_ss = ss;
    btn_lr = lr;
    step(7);
  endtask

  task automatic release_all();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    step(8);
  endtask

  task automatic tick_en(input string tag, input logic exp);
    tick = 1'b1;
    #1;
    chk(tag, {1'b0, cnt_en}, {1'b0, exp});
    step(1);
    tick = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    step(2);
    chk("rst_state", state, 2'b00);
    chk("rst_outs", {1'b0, cnt_clr | disp_latch | disp_hold | run_led | cnt_en}, 2'b00);
    rst = 1'b0;
    step(10);

    // Bounce must not produce a press
    btn_ss = 1'b1; step(2);
    btn_ss = 1'b0; step(2);
    btn_ss = 1'b1; step(2);
    btn_ss = 1'b0; step(12);
    chk("bounce_state", state, 2'b00);
    tick_en("bounce_cnt_en", 1'b0);

    // Held start: exactly one press, 7 clks after raw rise
    btn_ss = 1'b1;
    step(6);
    chk("ss_lat6", state, 2'b00);
    step(1);
    chk("ss_lat7", state, 2'b01);
    chk("run_led", {1'b0, run_led}, 2'b01);
    tick_en("run_cnt_en", 1'b1);
    chk("run_no_tick", {1'b0, cnt_en}, 2'b00);
    step(4);
    chk("hold_one_press", state, 2'b01);
    release_all();
    chk("after_release", state, 2'b01);

    // Lap freeze and return
    press(1'b0, 1'b1);
    chk("lap_state", state, 2'b10);
    chk("lap_latch", {1'b0, disp_latch}, 2'b01);
    chk("lap_hold", {1'b0, disp_hold}, 2'b01);
    step(1);
    chk("lap_latch_1clk", {1'b0, disp_latch}, 2'b00);
    tick_en("lap_cnt_en", 1'b1);
    release_all();
    press(1'b0, 1'b1);
    chk("lap_back_state", state, 2'b01);
    chk("lap_back_hold", {1'b0, disp_hold}, 2'b00);
    release_all();

    // Counter full: no enable, stop; then reset to idle
    cnt_max = 1'b1;
    tick = 1'b1;
    #1;
    chk("max_cnt_en", {1'b0, cnt_en}, 2'b00);
    step(1);
    tick = 1'b0;
    cnt_max = 1'b0;
    #1;
    chk("max_stop", state, 2'b11);
    chk("stop_led", {1'b0, run_led}, 2'b00);
    press(1'b0, 1'b1);
    chk("stop_lr_idle", state, 2'b00);
    chk("clr_pulse", {1'b0, cnt_clr}, 2'b01);
    step(1);
    chk("clr_1clk", {1'b0, cnt_clr}, 2'b00);
    release_all();

    // Simultaneous presses from STOP: start/stop wins
    press(1'b1, 1'b0);
    release_all();
    press(1'b1, 1'b0);
    chk("to_stop", state, 2'b11);
    release_all();
    press(1'b1, 1'b1);
    chk("both_state", state, 2'b01);
    chk("both_no_clr", {1'b0, cnt_clr}, 2'b00);
    release_all();
    chk("both_settled", state, 2'b01);

    // Reset during LAP with start held
    press(1'b0, 1'b1);
    chk("lap2_state", state, 2'b10);
    release_all();
    btn_ss = 1'b1;
    step(3);
    rst = 1'b1;
    tick = 1'b1;
    #1;
    chk("rst_mid_state", state, 2'b00);
    chk("rst_mid_outs", {1'b0, cnt_clr | disp_latch | disp_hold | run_led | cnt_en}, 2'b00);
    step(2);
    chk("rst_mid_hold", {1'b0, disp_hold | run_led | cnt_en}, 2'b00);
    tick = 1'b0;
    rst = 1'b0;
    step(20);
    chk("held_no_press", state, 2'b00);
    btn_ss = 1'b0;
    step(8);
    chk("released_idle", state, 2'b00);
    press(1'b1, 1'b0);
    chk("repress_run", state, 2'b01);
    release_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
